// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic inter-stage pipeline register with optional skid buffer
// Output register M drives the stage outputs; skid register S absorbs one beat when SKID=1.
module pipe_stage_reg #(
   parameter int DATA_W     = 32,
   parameter int CTRL_W     = 8,
   parameter int PC_W       = 32,
   parameter int SKID       = 1,
   parameter int CLEAR_DATA = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [PC_W-1:0]   in_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [PC_W-1:0]   out_pc,
   output logic [1:0]        occupancy,
   output logic [15:0]       stall_cnt
);

   logic              m_valid_q, m_valid_d;
   logic [DATA_W-1:0] m_data_q,  m_data_d;
   logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
   logic [PC_W-1:0]   m_pc_q,    m_pc_d;
   logic              s_valid_q, s_valid_d;
   logic [DATA_W-1:0] s_data_q,  s_data_d;
   logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
   logic [PC_W-1:0]   s_pc_q,    s_pc_d;
   logic [15:0]       stall_cnt_q, stall_cnt_d;

   logic ready_raw;
   logic accept;
   logic deliver;

   // With the skid buffer, ready depends only on state so no out_ready->in_ready path exists.
   always_comb begin
      if (SKID != 0) begin
         ready_raw = !s_valid_q;
      end else begin
         ready_raw = !m_valid_q || out_ready;
      end
      in_ready = ready_raw && !reset && !flush;
   end

   assign accept  = in_valid && in_ready;
   assign deliver = m_valid_q && out_ready;

   always_comb begin
      m_valid_d   = m_valid_q;
      m_data_d    = m_data_q;
      m_ctrl_d    = m_ctrl_q;
      m_pc_d      = m_pc_q;
      s_valid_d   = s_valid_q;
      s_data_d    = s_data_q;
      s_ctrl_d    = s_ctrl_q;
      s_pc_d      = s_pc_q;
      stall_cnt_d = stall_cnt_q;

      if (m_valid_q && !out_ready && stall_cnt_q != 16'hFFFF) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end

      if (reset) begin
         m_valid_d   = 1'b0;
         m_data_d    = '0;
         m_ctrl_d    = '0;
         m_pc_d      = '0;
         s_valid_d   = 1'b0;
         s_data_d    = '0;
         s_ctrl_d    = '0;
         s_pc_d      = '0;
         stall_cnt_d = '0;
      end else if (flush) begin
         m_valid_d = 1'b0;
         m_ctrl_d  = '0;
         s_valid_d = 1'b0;
         s_ctrl_d  = '0;
         if (CLEAR_DATA != 0) begin
            m_data_d = '0;
            m_pc_d   = '0;
            s_data_d = '0;
            s_pc_d   = '0;
         end
      end else if (SKID != 0 && s_valid_q) begin
         // Full: in_ready is low, so only a deliver can move the skid beat forward.
         if (deliver) begin
            m_valid_d = 1'b1;
            m_data_d  = s_data_q;
            m_ctrl_d  = s_ctrl_q;
            m_pc_d    = s_pc_q;
            s_valid_d = 1'b0;
            s_ctrl_d  = '0;
            if (CLEAR_DATA != 0) begin
               s_data_d = '0;
               s_pc_d   = '0;
            end
         end
      end else if (accept && (!m_valid_q || deliver)) begin
         m_valid_d = 1'b1;
         m_data_d  = in_data;
         m_ctrl_d  = in_ctrl;
         m_pc_d    = in_pc;
      end else if (accept) begin
         s_valid_d = 1'b1;
         s_data_d  = in_data;
         s_ctrl_d  = in_ctrl;
         s_pc_d    = in_pc;
      end else if (deliver) begin
         // Emptied M presents a bubble so valid-blind consumers see ctrl=0.
         m_valid_d = 1'b0;
         m_ctrl_d  = '0;
         if (CLEAR_DATA != 0) begin
            m_data_d = '0;
            m_pc_d   = '0;
         end
      end

      if (SKID == 0) begin
         s_valid_d = 1'b0;
         s_data_d  = '0;
         s_ctrl_d  = '0;
         s_pc_d    = '0;
      end
   end

   always_ff @(posedge clk) begin
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_ctrl_q    <= m_ctrl_d;
      m_pc_q      <= m_pc_d;
      s_valid_q   <= s_valid_d;
      s_data_q    <= s_data_d;
      s_ctrl_q    <= s_ctrl_d;
      s_pc_q      <= s_pc_d;
      stall_cnt_q <= stall_cnt_d;
   end

   assign out_valid = m_valid_q;
   assign out_data  = m_data_q;
   assign out_ctrl  = m_ctrl_q;
   assign out_pc    = m_pc_q;
   assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg (SKID=1 and SKID=0 builds)
// Both builds share stimulus; a queue-based model per build predicts every output.
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_data = '0;
   logic [7:0]  in_ctrl = '0;
   logic [31:0] in_pc = '0;

   logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
   logic [31:0] a_out_data, a_out_pc, b_out_data, b_out_pc;
   logic [7:0]  a_out_ctrl, b_out_ctrl;
   logic [1:0]  a_occ, b_occ;
   logic [15:0] a_stall, b_stall;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .PC_W(32), .SKID(1), .CLEAR_DATA(1)) dut_s (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(a_in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .in_pc(in_pc),
      .out_valid(a_out_valid), .out_ready(out_ready),
      .out_data(a_out_data), .out_ctrl(a_out_ctrl), .out_pc(a_out_pc),
      .occupancy(a_occ), .stall_cnt(a_stall)
   );

   pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .PC_W(32), .SKID(0), .CLEAR_DATA(1)) dut_n (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(b_in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .in_pc(in_pc),
      .out_valid(b_out_valid), .out_ready(out_ready),
      .out_data(b_out_data), .out_ctrl(b_out_ctrl), .out_pc(b_out_pc),
      .occupancy(b_occ), .stall_cnt(b_stall)
   );

   typedef struct {
      logic [31:0] d;
      logic [7:0]  c;
      logic [31:0] p;
   } beat_t;

   typedef struct {
      bit          fl;
      bit          iv;
      logic [31:0] d;
      bit          ordy;
      bit          e_ov;
      logic [31:0] e_od;
      logic [1:0]  e_occ;
      bit          e_rdy;
      logic [15:0] e_st;
   } vec_t;

   int checks = 0;
   int failures = 0;
   bit model_on = 1'b0;
   beat_t mq[2][$];
   int unsigned mstall[2];
   vec_t tbl[22];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input bit fl, input bit iv, input logic [31:0] d, input bit ordy);
      flush     = fl;
      in_valid  = iv;
      in_data   = d;
      in_ctrl   = d[7:0] ^ 8'h5A;
      in_pc     = d + 32'h1000;
      out_ready = ordy;
   endtask

   // FIFO of capacity 2 (skid) or 1 (no skid); the head is what the output should show.
   task automatic model_check_step();
      for (int k = 0; k < 2; k++) begin
         int    n;
         bit    er, dlv, acc;
         beat_t h;
         string t;
         t  = (k == 0) ? "skid" : "noskid";
         n  = mq[k].size();
         er = !flush && ((k == 0) ? (n < 2) : (n == 0 || out_ready));
         h  = '{32'h0, 8'h0, 32'h0};
         if (n > 0) h = mq[k][0];
         chk({t, "_in_ready"},  64'((k == 0) ? a_in_ready  : b_in_ready),  64'(er));
         chk({t, "_out_valid"}, 64'((k == 0) ? a_out_valid : b_out_valid), 64'(n > 0));
         chk({t, "_out_data"},  64'((k == 0) ? a_out_data  : b_out_data),  64'(h.d));
         chk({t, "_out_ctrl"},  64'((k == 0) ? a_out_ctrl  : b_out_ctrl),  64'(h.c));
         chk({t, "_out_pc"},    64'((k == 0) ? a_out_pc    : b_out_pc),    64'(h.p));
         chk({t, "_occupancy"}, 64'((k == 0) ? a_occ       : b_occ),       64'(n));
         chk({t, "_stall_cnt"}, 64'((k == 0) ? a_stall     : b_stall),     64'(mstall[k]));
         dlv = (n > 0) && out_ready;
         acc = in_valid && er;
         if (n > 0 && !out_ready && mstall[k] < 65535) mstall[k]++;
         if (flush) begin
            mq[k].delete();
         end else begin
            if (dlv) void'(mq[k].pop_front());
            if (acc) mq[k].push_back('{in_data, in_ctrl, in_pc});
         end
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      if (model_on) model_check_step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mq[k].delete();
         mstall[k] = 0;
      end
   endtask

   initial begin
      //          fl iv data      rdy  ov  out_data  occ rdy stall
      tbl[0]  = '{0, 1, 32'h11, 1,  0, 32'h00, 0, 1, 0};
      tbl[1]  = '{0, 1, 32'h22, 1,  1, 32'h11, 1, 1, 0};
      tbl[2]  = '{0, 1, 32'h33, 1,  1, 32'h22, 1, 1, 0};
      tbl[3]  = '{0, 0, 32'h00, 1,  1, 32'h33, 1, 1, 0};
      tbl[4]  = '{0, 0, 32'h00, 1,  0, 32'h00, 0, 1, 0};
      tbl[5]  = '{0, 1, 32'hA0, 1,  0, 32'h00, 0, 1, 0};
      tbl[6]  = '{0, 1, 32'hA1, 0,  1, 32'hA0, 1, 1, 0};
      tbl[7]  = '{0, 1, 32'hA2, 0,  1, 32'hA0, 2, 0, 1};
      tbl[8]  = '{0, 1, 32'hA2, 0,  1, 32'hA0, 2, 0, 2};
      tbl[9]  = '{0, 1, 32'hA2, 1,  1, 32'hA0, 2, 0, 3};
      tbl[10] = '{0, 1, 32'hA2, 1,  1, 32'hA1, 1, 1, 3};
      tbl[11] = '{0, 1, 32'hA3, 1,  1, 32'hA2, 1, 1, 3};
      tbl[12] = '{0, 0, 32'h00, 1,  1, 32'hA3, 1, 1, 3};
      tbl[13] = '{0, 0, 32'h00, 1,  0, 32'h00, 0, 1, 3};
      tbl[14] = '{0, 1, 32'hB0, 0,  0, 32'h00, 0, 1, 3};
      tbl[15] = '{0, 1, 32'hB1, 0,  1, 32'hB0, 1, 1, 3};
      tbl[16] = '{1, 1, 32'h55, 0,  1, 32'hB0, 2, 0, 4};
      tbl[17] = '{0, 0, 32'h00, 0,  0, 32'h00, 0, 1, 5};
      tbl[18] = '{0, 1, 32'h10, 1,  0, 32'h00, 0, 1, 5};
      tbl[19] = '{0, 1, 32'h20, 1,  1, 32'h10, 1, 1, 5};
      tbl[20] = '{0, 0, 32'h00, 1,  1, 32'h20, 1, 1, 5};
      tbl[21] = '{0, 0, 32'h00, 0,  0, 32'h00, 0, 1, 5};

      // Reset for two cycles; in_ready must be low throughout.
      @(posedge clk); #1;
      @(negedge clk);
      chk("reset_in_ready_skid", 64'(a_in_ready), 64'(0));
      chk("reset_in_ready_noskid", 64'(b_in_ready), 64'(0));
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      model_on = 1'b1;

      for (int i = 0; i < 22; i++) begin
         drive(tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
         @(negedge clk);
         chk($sformatf("vec%0d_out_valid", i), 64'(a_out_valid), 64'(tbl[i].e_ov));
         chk($sformatf("vec%0d_out_data", i),  64'(a_out_data),  64'(tbl[i].e_od));
         chk($sformatf("vec%0d_out_ctrl", i),  64'(a_out_ctrl),
             64'(tbl[i].e_ov ? (tbl[i].e_od[7:0] ^ 8'h5A) : 8'h00));
         chk($sformatf("vec%0d_out_pc", i),    64'(a_out_pc),
             64'(tbl[i].e_ov ? (tbl[i].e_od + 32'h1000) : 32'h0));
         chk($sformatf("vec%0d_occupancy", i), 64'(a_occ),       64'(tbl[i].e_occ));
         chk($sformatf("vec%0d_in_ready", i),  64'(a_in_ready),  64'(tbl[i].e_rdy));
         chk($sformatf("vec%0d_stall_cnt", i), 64'(a_stall),     64'(tbl[i].e_st));
         model_check_step();
         @(posedge clk); #1;
      end

      // No-skid build: in_ready follows out_ready combinationally while M is full.
      drive(0, 1, 32'h77, 0);
      cyc();
      drive(0, 1, 32'h88, 0);
      @(negedge clk);
      chk("noskid_full_blocked", 64'(b_in_ready), 64'(0));
      chk("noskid_full_valid", 64'(b_out_valid), 64'(1));
      #1;
      out_ready = 1'b1;
      #1;
      chk("noskid_ready_comb", 64'(b_in_ready), 64'(1));
      chk("skid_ready_not_comb", 64'(a_in_ready), 64'(1));
      model_check_step();
      @(posedge clk); #1;

      for (int i = 0; i < 3000; i++) begin
         flush     = ($urandom_range(0, 31) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_data   = $urandom;
         in_ctrl   = 8'($urandom);
         in_pc     = $urandom;
         cyc();
      end

      // Counter saturation over a long stall, then flush and reset.
      drive(0, 1, 32'hC0, 0);
      cyc();
      drive(0, 0, 32'h0, 0);
      model_on = 1'b0;
      repeat (70000) @(posedge clk);
      #1;
      @(negedge clk);
      chk("sat_stall_skid", 64'(a_stall), 64'(16'hFFFF));
      chk("sat_stall_noskid", 64'(b_stall), 64'(16'hFFFF));
      chk("sat_out_valid", 64'(a_out_valid), 64'(1));
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_keeps_stall", 64'(a_stall), 64'(16'hFFFF));
      chk("flush_out_valid", 64'(a_out_valid), 64'(0));
      chk("flush_out_ctrl", 64'(a_out_ctrl), 64'(0));
      chk("flush_out_data", 64'(a_out_data), 64'(0));
      chk("flush_occupancy", 64'(a_occ), 64'(0));
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("reset_clears_stall_skid", 64'(a_stall), 64'(0));
      chk("reset_clears_stall_noskid", 64'(b_stall), 64'(0));
      chk("reset_out_valid", 64'(a_out_valid), 64'(0));
      chk("reset_occupancy", 64'(a_occ), 64'(0));
      chk("reset_in_ready_after", 64'(a_in_ready), 64'(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised, elastic inter-stage pipeline register and the successor to the fixed MEM/WB-style latch. It carries a data payload, a control bundle and a PC between two pipeline stages using a valid/ready handshake. It provides an optional 2-entry skid buffer for full throughput without a combinational ready path, plus exception flush with bubble insertion and a stall-cycle performance counter. One instance is placed per stage boundary (F/D, D/E, E/M, M/W).

Parameters:
DATA_W, 32, width of the concatenated data payload (result, store data, load data, A3, ...)
CTRL_W, 8, width of the control bundle (RegWE, WB select, SL ctrl, ...); forced to 0 in bubbles
PC_W, 32, width of the PC field
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
CLEAR_DATA, 1, 1 = data and PC are zeroed whenever the output register is empty or flushed; 0 = they hold their last value

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  exception clear; kills all stored beats and the incoming beat
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept a beat this cycle
in_data  in  DATA_W  upstream payload
in_ctrl  in  CTRL_W  upstream control bundle
in_pc  in  PC_W  upstream PC
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts the beat this cycle
out_data  out  DATA_W  payload from the output register M
out_ctrl  out  CTRL_W  control from M; always 0 when out_valid=0
out_pc  out  PC_W  PC from M
occupancy  out  2  number of held beats (0..2; max 1 when SKID=0)
stall_cnt  out  16  cycles where out_valid=1 and out_ready=0

Behaviour:
- Storage is output register M (fields: valid, data, ctrl, pc) and, when SKID=1, skid register S with the same fields. Outputs come from M only.
- Accept event: in_valid && in_ready. Deliver event: out_valid && out_ready. Both may occur in the same cycle.
- Reset (priority 1): M.valid=S.valid=0; all data, ctrl and pc fields = 0; stall_cnt=0. During reset, in_ready=0. After reset, out_valid=0, out_ctrl=0, out_data=0, out_pc=0, occupancy=0.
- Flush (priority 2):
  - in_ready is forced 0 combinationally, so the incoming beat is rejected.
  - out_valid is not masked; a deliver event in the flush cycle counts as delivered.
  - Next cycle: M.valid=S.valid=0, M.ctrl=0, S.ctrl=0. Data and PC are zeroed when CLEAR_DATA=1.
  - stall_cnt is not cleared by flush.
- SKID=1: in_ready = !S.valid, registered only with no combinational dependence on out_ready.
  - occ 0, accept: M <= in; occ becomes 1.
  - occ 1, accept and deliver: M <= in; occ stays 1.
  - occ 1, accept, no deliver: S <= in; occ becomes 2.
  - occ 1, deliver only: occ becomes 0.
  - occ 2, deliver: M <= S; occ becomes 1. No accept is possible because in_ready=0.
  - occ 2, no deliver: hold.
  - Order is strictly FIFO. A beat is never duplicated or dropped except by flush.
- SKID=0: in_ready = !M.valid || out_ready (combinational). Accept loads M. A deliver with no accept empties M.
- Whenever M becomes empty: M.ctrl <= 0, and M.data and M.pc <= 0 when CLEAR_DATA=1. Legacy consumers that decode RegWE without checking valid therefore see a bubble.
- Latency: accept in cycle N makes out_valid=1 in cycle N+1 when M was empty or was delivered in cycle N. Throughput is 1 beat/cycle in both modes.
- stall_cnt: increments by 1 in every cycle where out_valid && !out_ready. It saturates at 0xFFFF and is cleared only by reset.
- occupancy = M.valid + S.valid.
- Upstream may change in_* while in_ready=0; those values are ignored.

Test Plan:
- Reset then stream: reset 2 cycles; then in_valid=1 with in_data=0x11,0x22,0x33 on consecutive cycles and out_ready=1 -> out_data 0x11,0x22,0x33 on cycles 1..3 after their accepts; occupancy stays 1; stall_cnt=0.
- Backpressure with SKID=1: stream 0xA0..0xA3, out_ready=0 from the second beat -> occupancy reaches 2; in_ready=0; holds 3 cycles so stall_cnt=3; on release, outputs are 0xA0,0xA1,0xA2,0xA3 in order with no loss.
- Flush mid-stream: occupancy=2 and flush=1 with in_valid=1, in_data=0x55 -> in_ready=0 that cycle; next cycle out_valid=0, out_ctrl=0, out_data=0, occupancy=0; 0x55 never appears.
- Simultaneous accept and deliver at occ 1: M holds 0x10, in 0x20, out_ready=1 -> 0x10 delivered; next cycle out_data=0x20; occupancy=1.
- SKID=0 build: out_ready=0 with M full -> in_ready=0 in the same cycle; raise out_ready -> in_ready=1 combinationally in that same cycle.
- Counter saturation: hold out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=0xFFFF; apply flush -> stays 0xFFFF; apply reset -> becomes 0.
